softmax_out_writer: RTL



---
 rtl/softmax_out_writer.sv | 113 +++++++++++
 1 files changed

// File: rtl/softmax_out_writer.sv
// Output writer for the softmax engine: packs four result lanes per valid cycle
// into one memory word and streams the words through a small FIFO to a ready-gated write port.
module softmax_out_writer #(
  parameter int DATAWIDTH  = 16,
  parameter int NUM        = 4,
  parameter int ADDRSIZE   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic [ADDRSIZE-1:0]     out_start_addr,
  input  logic [ADDRSIZE-1:0]     out_end_addr,
  input  logic                    in_valid,
  input  logic [DATAWIDTH-1:0]    in_data0,
  input  logic [DATAWIDTH-1:0]    in_data1,
  input  logic [DATAWIDTH-1:0]    in_data2,
  input  logic [DATAWIDTH-1:0]    in_data3,
  output logic                    wr_en,
  output logic [ADDRSIZE-1:0]     wr_addr,
  output logic [DATAWIDTH*NUM-1:0] wr_data,
  input  logic                    wr_ready,
  output logic                    busy,
  output logic                    complete,
  output logic [ADDRSIZE:0]       count,
  output logic                    overflow,
  output logic                    addr_err
);

  localparam int WORD_W = DATAWIDTH * NUM;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ARMED, STREAM, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [WORD_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr;
  logic                fifo_empty, fifo_full;
  logic [ADDRSIZE:0]   addr_cnt;
  logic [ADDRSIZE-1:0] end_addr;
  logic                past_end, pop, push_req, push;
  logic [WORD_W-1:0]   in_word;

  assign in_word    = {in_data3, in_data2, in_data1, in_data0};
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // The counter is one bit wider than the address so "one past the end" never wraps to zero.
  assign past_end = (addr_cnt > {1'b0, end_addr});
  assign pop      = !fifo_empty && (past_end || wr_ready);
  assign push_req = in_valid && ((state == ARMED) || (state == STREAM));
  assign push     = push_req && (!fifo_full || pop);

  assign wr_en    = !fifo_empty && !past_end;
  assign wr_addr  = addr_cnt[ADDRSIZE-1:0];
  assign wr_data  = fifo_empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];
  assign busy     = (state != IDLE);
  assign complete = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm)        state_next = ARMED;
      ARMED:   if (in_valid)   state_next = STREAM;
      STREAM:  if (!in_valid)  state_next = DRAIN;
      DRAIN:   if (fifo_empty) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= in_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      addr_cnt <= '0;
      end_addr <= '0;
      count    <= '0;
      overflow <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if ((state == IDLE) && arm) begin
        addr_cnt <= {1'b0, out_start_addr};
        end_addr <= out_end_addr;
        count    <= '0;
        overflow <= 1'b0;
        addr_err <= 1'b0;
      end else begin
        if (pop && !past_end) begin
          if (addr_cnt != '1) addr_cnt <= addr_cnt + 1'b1;
          count <= count + 1'b1;
        end
        if (pop && past_end)     addr_err <= 1'b1;
        if (push_req && !push)   overflow <= 1'b1;
      end
    end
  end

endmodule
